// File: rtl/stack_alu_sequencer_pkg.sv
// Shared definitions for the stack ALU sequencer: widths, opcodes, FSM states
// and the operand-count lookup used to decide how many pops an opcode needs.
package stack_alu_sequencer_pkg;

  localparam int DEF_OP_W  = 16;
  localparam int DEF_RES_W = 32;
  localparam int DEF_OPC_W = 4;

  localparam logic [3:0] OPC_ADD = 4'd0;
  localparam logic [3:0] OPC_SUB = 4'd1;
  localparam logic [3:0] OPC_MUL = 4'd2;
  localparam logic [3:0] OPC_AND = 4'd3;
  localparam logic [3:0] OPC_OR  = 4'd4;
  localparam logic [3:0] OPC_XOR = 4'd5;
  localparam logic [3:0] OPC_NOT = 4'd6;
  localparam logic [3:0] OPC_SHL = 4'd7;
  localparam logic [3:0] OPC_SHR = 4'd8;
  localparam logic [3:0] OPC_LT  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_POPB, S_POPA, S_CAPU, S_CAPA, S_EXEC, S_PUSH, S_FIN
  } state_t;

  // 0 marks an illegal opcode.
  function automatic logic [1:0] op_count(input logic [3:0] opc);
    case (opc)
      OPC_NOT: return 2'd1;
      OPC_ADD, OPC_SUB, OPC_MUL, OPC_AND, OPC_OR,
      OPC_XOR, OPC_SHL, OPC_SHR, OPC_LT: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_alu_core.sv
// Combinational ALU: result = f(opcode, a, b). Binary ops compute a op b,
// NOT operates on b alone.
module stack_alu_core
  import stack_alu_sequencer_pkg::*;
#(
  parameter int OP_W  = DEF_OP_W,
  parameter int RES_W = DEF_RES_W,
  parameter int OPC_W = DEF_OPC_W
) (
  input  logic [OPC_W-1:0] i_opc,
  input  logic [OP_W-1:0]  i_a,
  input  logic [OP_W-1:0]  i_b,
  output logic [RES_W-1:0] o_res
);

  logic [OP_W:0]    w_sum;
  logic [OP_W-1:0]  w_diff;
  logic [OP_W-1:0]  w_not;
  logic [RES_W-1:0] w_a_ext;
  logic [RES_W-1:0] w_b_ext;

  // Intermediates keep ADD/SUB/NOT at operand width before extension.
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = i_a - i_b;
  assign w_not   = ~i_b;
  assign w_a_ext = {{(RES_W-OP_W){1'b0}}, i_a};
  assign w_b_ext = {{(RES_W-OP_W){1'b0}}, i_b};

  always_comb begin
    o_res = '0;
    case (i_opc)
      OPC_ADD: o_res = {{(RES_W-OP_W-1){1'b0}}, w_sum};
      OPC_SUB: o_res = {{(RES_W-OP_W){w_diff[OP_W-1]}}, w_diff};
      OPC_MUL: o_res = w_a_ext * w_b_ext;
      OPC_AND: o_res = w_a_ext & w_b_ext;
      OPC_OR:  o_res = w_a_ext | w_b_ext;
      OPC_XOR: o_res = w_a_ext ^ w_b_ext;
      OPC_NOT: o_res = {{(RES_W-OP_W){1'b0}}, w_not};
      OPC_SHL: o_res = w_a_ext << i_b[3:0];
      OPC_SHR: o_res = w_a_ext >> i_b[3:0];
      OPC_LT:  o_res = {{(RES_W-1){1'b0}}, (i_a < i_b)};
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/stack_alu_sequencer.sv
// Execution stage beside the operand stack: pops operands, runs the ALU,
// pushes the result and reports done/busy/error flags to the control unit.
module stack_alu_sequencer
  import stack_alu_sequencer_pkg::*;
#(
  parameter int OP_W  = DEF_OP_W,
  parameter int RES_W = DEF_RES_W,
  parameter int OPC_W = DEF_OPC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic [OP_W-1:0]  stk_dout,
  input  logic [15:0]      stk_tos,
  output logic             stk_push,
  output logic             stk_pop,
  output logic             stk_sel_alu,
  output logic [RES_W-1:0] stk_din,
  output logic             busy,
  output logic             done,
  output logic             err_under,
  output logic             err_opc,
  output logic             zero
);

  state_t           r_state, w_next;
  logic [OPC_W-1:0] r_opc;
  logic [OP_W-1:0]  r_a, r_b;
  logic [RES_W-1:0] r_din;
  logic             r_zero, r_err_under, r_err_opc;
  logic [1:0]       w_need;
  logic             w_illegal, w_short;
  logic [RES_W-1:0] w_res;

  assign w_need    = op_count(opcode);
  assign w_illegal = (w_need == 2'd0);
  assign w_short   = (stk_tos < {14'b0, w_need});

  stack_alu_core #(.OP_W(OP_W), .RES_W(RES_W), .OPC_W(OPC_W)) u_core (
    .i_opc (r_opc),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_res (w_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_din       <= '0;
      r_zero      <= 1'b0;
      r_err_under <= 1'b0;
      r_err_opc   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_opc       <= opcode;
          r_err_opc   <= w_illegal;
          r_err_under <= !w_illegal && w_short;
        end
        // stk_dout lags the pop by one cycle, so b lands while a is being popped.
        S_POPA, S_CAPU: r_b <= stk_dout;
        S_CAPA:         r_a <= stk_dout;
        S_EXEC: begin
          r_din  <= w_res;
          r_zero <= (w_res == '0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    stk_pop     = 1'b0;
    stk_push    = 1'b0;
    stk_sel_alu = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = (w_illegal || w_short) ? S_FIN : S_POPB;
      S_POPB: begin
        stk_pop = 1'b1;
        w_next  = (op_count(r_opc) == 2'd1) ? S_CAPU : S_POPA;
      end
      S_POPA: begin
        stk_pop = 1'b1;
        w_next  = S_CAPA;
      end
      S_CAPU, S_CAPA: w_next = S_EXEC;
      S_EXEC: w_next = S_PUSH;
      S_PUSH: begin
        stk_push    = 1'b1;
        stk_sel_alu = 1'b1;
        w_next      = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign stk_din   = r_din;
  assign zero      = r_zero;
  assign err_under = r_err_under;
  assign err_opc   = r_err_opc;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural stack harness plus a queue-based
// reference of the stack contents and ALU results.
module tb_stack_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [15:0] stk_dout = '0;
  logic [15:0] stk_tos = '0;
  logic        stk_push, stk_pop, stk_sel_alu;
  logic [31:0] stk_din;
  logic        busy, done, err_under, err_opc, zero;

  logic        ld_en = 1'b0, ld_clr = 1'b0;
  logic [15:0] ld_val = '0;
  logic [15:0] stk_q[$];

  logic [15:0] mdl_q[$];
  logic [31:0] mdl_din;
  logic        mdl_zero;
  logic [31:0] last_pv;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  stack_alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .stk_dout(stk_dout), .stk_tos(stk_tos),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_sel_alu(stk_sel_alu),
    .stk_din(stk_din), .busy(busy), .done(done),
    .err_under(err_under), .err_opc(err_opc), .zero(zero)
  );

  // Stack harness: registered read data, tos reflects the updated occupancy.
  always @(posedge clk) begin
    if (ld_clr) stk_q.delete();
    if (ld_en) stk_q.push_back(ld_val);
    if (stk_pop && stk_q.size() > 0) stk_dout <= stk_q.pop_back();
    if (stk_push && stk_sel_alu) stk_q.push_back(stk_din[15:0]);
    stk_tos <= 16'(stk_q.size());
  end

  function automatic logic [31:0] ref_alu(input int opc, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = a - b;
    case (opc)
      0: return 32'(a) + 32'(b);
      1: return {{16{d[15]}}, d};
      2: return 32'(a) * 32'(b);
      3: return 32'(a & b);
      4: return 32'(a | b);
      5: return 32'(a ^ b);
      6: return {16'h0000, ~b};
      7: return 32'(a) << b[3:0];
      8: return 32'(a) >> b[3:0];
      9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic load(input logic [15:0] v);
    @(negedge clk); ld_en = 1'b1; ld_val = v;
    @(negedge clk); ld_en = 1'b0;
    mdl_q.push_back(v);
  endtask

  task automatic clear_stack();
    @(negedge clk); ld_clr = 1'b1;
    @(negedge clk); ld_clr = 1'b0;
    mdl_q.delete();
  endtask

  // Issue one operation, observe it to completion and compare with the model.
  // restart_at > 0 re-pulses start (with another opcode) in that cycle.
  task automatic run_op(input logic [3:0] opc, input int restart_at, input string tag);
    logic [15:0] a, b;
    logic [31:0] r;
    int need, lat_exp, cyc, npop, npush, nboth, nsel;
    bit ill, und, seen_done, busy1, e_opc, e_und;
    ill = (opc > 9);
    need = (opc == 6) ? 1 : 2;
    und = !ill && (mdl_q.size() < need);
    e_opc = ill; e_und = und;
    if (ill || und) begin
      lat_exp = 1; need = 0;
    end else begin
      b = mdl_q.pop_back();
      a = (need == 2) ? mdl_q.pop_back() : 16'h0;
      r = ref_alu(int'(opc), a, b);
      mdl_q.push_back(r[15:0]);
      mdl_din = r; mdl_zero = (r == 32'd0);
      lat_exp = (need == 2) ? 6 : 5;
    end
    @(negedge clk); start = 1'b1; opcode = opc;
    cyc = 0; npop = 0; npush = 0; nboth = 0; nsel = 0; seen_done = 0; busy1 = 0; last_pv = 'x;
    while (!seen_done && cyc < 20) begin
      @(negedge clk); cyc++;
      start  = (cyc == restart_at);
      opcode = start ? 4'd5 : opc;
      if (stk_pop) npop++;
      if (stk_push) begin npush++; last_pv = stk_din; if (!stk_sel_alu) nsel++; end
      if (stk_pop && stk_push) nboth++;
      if (cyc == 1) busy1 = busy;
      if (done) seen_done = 1;
    end
    start = 1'b0;
    n_checks++;
    if (!seen_done) begin
      n_fail++; $display("FAIL %s timeout: no done within 20 cycles", tag);
    end
    n_checks++;
    if (cyc !== lat_exp) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, lat_exp); end
    n_checks++;
    if (npop !== need) begin n_fail++; $display("FAIL %s pops: got %0d want %0d", tag, npop, need); end
    n_checks++;
    if (npush !== ((ill || und) ? 0 : 1)) begin n_fail++; $display("FAIL %s pushes: got %0d", tag, npush); end
    n_checks++;
    if (nboth !== 0 || nsel !== 0) begin n_fail++; $display("FAIL %s handshake: both=%0d nosel=%0d", tag, nboth, nsel); end
    n_checks++;
    if (!(ill || und) && last_pv !== mdl_din) begin n_fail++; $display("FAIL %s pushed: got %h want %h", tag, last_pv, mdl_din); end
    n_checks++;
    if (stk_din !== mdl_din || zero !== mdl_zero) begin
      n_fail++; $display("FAIL %s din/zero: got %h/%b want %h/%b", tag, stk_din, zero, mdl_din, mdl_zero);
    end
    n_checks++;
    if (err_opc !== e_opc || err_under !== e_und) begin
      n_fail++; $display("FAIL %s errs: got opc=%b under=%b want %b/%b", tag, err_opc, err_under, e_opc, e_und);
    end
    n_checks++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b want 1", tag, busy1); end
    n_checks++;
    if (stk_tos !== 16'(mdl_q.size())) begin n_fail++; $display("FAIL %s tos: got %0d want %0d", tag, stk_tos, mdl_q.size()); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL %s idle: busy=%b done=%b want 0/0", tag, busy, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({stk_push, stk_pop, stk_sel_alu, busy, done, err_under, err_opc, zero} !== 8'h00 || stk_din !== 32'h0) begin
      n_fail++; $display("FAIL reset outputs: flags=%b din=%h want 0", {stk_push, stk_pop, stk_sel_alu, busy, done, err_under, err_opc, zero}, stk_din);
    end
    rst = 1'b0;
    mdl_din = '0; mdl_zero = 1'b0;
  endtask

  task automatic test_directed();
    clear_stack(); load(16'd5); load(16'd3);
    run_op(4'd0, 0, "add");
    n_checks++;
    if (last_pv !== 32'h0000_0008) begin n_fail++; $display("FAIL add value: got %h want 00000008", last_pv); end
    clear_stack(); load(16'd3); load(16'd5);
    run_op(4'd1, 0, "sub");
    n_checks++;
    if (last_pv !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub value: got %h want fffffffe", last_pv); end
    clear_stack(); load(16'hFFFF); load(16'hFFFF);
    run_op(4'd2, 0, "mul");
    n_checks++;
    if (last_pv !== 32'hFFFE_0001) begin n_fail++; $display("FAIL mul value: got %h want fffe0001", last_pv); end
  endtask

  task automatic test_errors();
    clear_stack(); load(16'h1234);
    run_op(4'd0, 0, "under");
    load(16'h00FF);
    run_op(4'd6, 0, "not");
    n_checks++;
    if (last_pv !== 32'h0000_FF00) begin n_fail++; $display("FAIL not value: got %h want 0000ff00", last_pv); end
    run_op(4'd12, 0, "illegal");
    load(16'h0F0F); load(16'hF0F0);
    run_op(4'd3, 2, "and_restart");
    n_checks++;
    if (last_pv !== 32'h0 || zero !== 1'b1) begin n_fail++; $display("FAIL and value: got %h zero=%b want 0/1", last_pv, zero); end
  endtask

  task automatic test_reset_mid();
    int npush;
    clear_stack(); load(16'd7); load(16'd9);
    @(negedge clk); start = 1'b1; opcode = 4'd0;
    npush = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); start = 1'b0;
      if (stk_push) npush++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (stk_push) npush++;
    n_checks++;
    if (npush !== 0) begin n_fail++; $display("FAIL rst_mid push: got %0d pushes want 0", npush); end
    n_checks++;
    if ({stk_push, stk_pop, stk_sel_alu, busy, done, err_under, err_opc, zero} !== 8'h00 || stk_din !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid outputs: flags=%b din=%h want 0", {stk_push, stk_pop, stk_sel_alu, busy, done, err_under, err_opc, zero}, stk_din);
    end
    rst = 1'b0;
    void'(mdl_q.pop_back()); void'(mdl_q.pop_back());
    mdl_din = '0; mdl_zero = 1'b0;
    load(16'd20); load(16'd22);
    run_op(4'd0, 0, "add_after_rst");
  endtask

  task automatic test_random();
    logic [3:0] opc;
    int nl;
    for (int i = 0; i < 60; i++) begin
      if (mdl_q.size() > 6) clear_stack();
      nl = $urandom_range(0, 2);
      for (int k = 0; k < nl; k++)
        load(($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom));
      opc = ($urandom_range(0, 4) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      run_op(opc, ($urandom_range(0, 3) == 0) ? 2 : 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
